// File: rtl/uart_pkg.sv
// Shared UART constants: baud-rate table, divisor rounding and minimum divisor.
package uart_pkg;

    localparam int BR_SEL_W  = 3;
    localparam int NUM_RATES = 1 << BR_SEL_W;

    // Baud rates selectable through br_sel, index 0 .. 7
    localparam int unsigned BAUD_RATES [NUM_RATES] = '{
        32'd4800, 32'd9600, 32'd14400, 32'd19200,
        32'd38400, 32'd57600, 32'd115200, 32'd230400
    };

    // Bit period in clock cycles, rounded to nearest
    function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

    // Smallest usable bit period: at least two clocks per oversample tick
    function automatic int unsigned min_div(input int unsigned oversample);
        return 2 * oversample;
    endfunction

endpackage

// File: rtl/uart_baud_gen_if.sv
// Rate request / tick bundle between the UART datapaths and the baud engine.
interface uart_baud_gen_if #(
    parameter int DIV_W = 16
);
    import uart_pkg::*;

    logic [BR_SEL_W-1:0] br_sel;
    logic                use_custom;
    logic [DIV_W-1:0]    custom_div;
    logic                tx_idle;
    logic                rx_idle;
    logic                resync;
    logic [DIV_W-1:0]    active_div;
    logic                bit_tick;
    logic                os_tick;
    logic                rate_changed;

    // Requesting side (UART control / datapaths)
    modport master (
        output br_sel, use_custom, custom_div, tx_idle, rx_idle, resync,
        input  active_div, bit_tick, os_tick, rate_changed
    );

    // Baud engine side
    modport slave (
        input  br_sel, use_custom, custom_div, tx_idle, rx_idle, resync,
        output active_div, bit_tick, os_tick, rate_changed
    );

endinterface

// File: rtl/uart_tick_div.sv
// Bit-period counter plus Bresenham accumulator that spreads OVERSAMPLE
// ticks evenly over each bit period without drifting against bit_tick.
module uart_tick_div #(
    parameter int          DIV_W      = 16,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             bit_tick,
    output logic             os_tick
);

    localparam logic [DIV_W:0] OS_STEP = (DIV_W + 1)'(OVERSAMPLE);

    logic [DIV_W-1:0] cnt_reg;
    logic [DIV_W:0]   acc_reg;
    logic [DIV_W:0]   acc_next;
    logic [DIV_W:0]   div_ext;
    logic             bit_tick_reg;
    logic             os_tick_reg;
    logic             bit_wrap;
    logic             os_wrap;

    assign div_ext  = {1'b0, div};
    assign acc_next = acc_reg + OS_STEP;
    assign os_wrap  = (acc_next >= div_ext);
    assign bit_wrap = (cnt_reg == div - 1'b1);

    // Bit counter: wraps at div-1, tick registered so it lands in cycle div
    always_ff @(posedge clk) begin
        if (srst || clr) begin
            cnt_reg      <= '0;
            bit_tick_reg <= 1'b0;
        end else begin
            bit_tick_reg <= bit_wrap;
            cnt_reg      <= bit_wrap ? '0 : cnt_reg + 1'b1;
        end
    end

    // Oversample accumulator: adds OVERSAMPLE per clock, ticks on each overflow of div
    always_ff @(posedge clk) begin
        if (srst || clr) begin
            acc_reg     <= '0;
            os_tick_reg <= 1'b0;
        end else begin
            os_tick_reg <= os_wrap;
            acc_reg     <= os_wrap ? acc_next - div_ext : acc_next;
        end
    end

    assign bit_tick = bit_tick_reg;
    assign os_tick  = os_tick_reg;

endmodule

// File: rtl/uart_baud_gen.sv
// Baud-rate engine: picks a table or custom divisor, clamps it, commits it
// only while both directions are idle, and drives the shared tick generator.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 100000000,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int          DIV_W      = 16,
    parameter int unsigned RESET_SEL  = 6
) (
    input  logic            clk,
    input  logic            rst,
    uart_baud_gen_if.slave  bus
);

    localparam logic [DIV_W-1:0] MIN_DIV   = DIV_W'(min_div(OVERSAMPLE));
    localparam logic [DIV_W-1:0] RESET_DIV = DIV_W'(calc_div(CLK_HZ, BAUD_RATES[RESET_SEL]));

    logic [DIV_W-1:0] table_div [NUM_RATES];
    logic [DIV_W-1:0] req_raw;
    logic [DIV_W-1:0] req_div;
    logic [DIV_W-1:0] active_div_reg;
    logic             rate_changed_reg;
    logic             commit;

    // Divisor table, fixed at elaboration from CLK_HZ
    for (genvar gi = 0; gi < NUM_RATES; gi++) begin : g_table
        assign table_div[gi] = DIV_W'(calc_div(CLK_HZ, BAUD_RATES[gi]));
    end

    assign req_raw = bus.use_custom ? bus.custom_div : table_div[bus.br_sel];
    assign req_div = (req_raw < MIN_DIV) ? MIN_DIV : req_raw;
    // Request is not latched: it must still differ when both sides go idle
    assign commit  = bus.tx_idle && bus.rx_idle && (req_div != active_div_reg);

    // Committed divisor and one-cycle change strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            active_div_reg   <= RESET_DIV;
            rate_changed_reg <= 1'b0;
        end else begin
            rate_changed_reg <= commit;
            if (commit) begin
                active_div_reg <= req_div;
            end
        end
    end

    uart_tick_div #(
        .DIV_W      (DIV_W),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_tick_div (
        .clk      (clk),
        .srst     (rst),
        .clr      (commit || bus.resync),
        .div      (active_div_reg),
        .bit_tick (bus.bit_tick),
        .os_tick  (bus.os_tick)
    );

    assign bus.active_div   = active_div_reg;
    assign bus.rate_changed = rate_changed_reg;

endmodule

// File: doc/uart_baud_gen.md
Name: uart_baud_gen

Overview:
- Parametrised baud-rate engine shared by the UART receiver and transmitter.
- Selects a bit period from an elaboration-time rate table or from a runtime custom divisor.
- Commits a rate change only while both directions are idle.
- Generates a bit-rate tick (Tx) and an evenly spread oversample tick (Rx), so neither datapath needs its own divide counter.

Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz; used to compute table divisors.
- OVERSAMPLE, 16, Rx oversample ticks per bit period; must be >= 1; need not be a power of two.
- DIV_W, 16, width of divisor and bit counter.
- RESET_SEL, 6, table index loaded at reset (115200 baud).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- br_sel  in  3  table index: 0=4800, 1=9600, 2=14400, 3=19200, 4=38400, 5=57600, 6=115200, 7=230400
- use_custom  in  1  1 = take custom_div instead of the table entry
- custom_div  in  DIV_W  custom bit period in clk cycles
- tx_idle  in  1  transmitter has no frame in progress
- rx_idle  in  1  receiver has no frame in progress
- resync  in  1  restart both tick phases (Rx start-edge alignment)
- active_div  out  DIV_W  committed bit period in clk cycles
- bit_tick  out  1  one-cycle pulse per bit period
- os_tick  out  1  one-cycle pulse, OVERSAMPLE per bit period
- rate_changed  out  1  one-cycle pulse when a new divisor is committed

Behaviour:
- Table divisor for baud rate r: round(CLK_HZ / r), computed at elaboration. At 100 MHz: 20833, 10417, 6944, 5208, 2604, 1736, 868, 434.
- Requested divisor: req_div = use_custom ? custom_div : TABLE[br_sel].
- Clamp: if req_div < 2*OVERSAMPLE, req_div = 2*OVERSAMPLE. This covers custom_div = 0.
- Reset, while rst is high at a clk edge:
  - active_div = TABLE[RESET_SEL]
  - bit counter = 0, os accumulator = 0
  - bit_tick = 0, os_tick = 0, rate_changed = 0
- Commit rule: a change is committed on a clk edge when tx_idle && rx_idle && req_div != active_div. On that edge:
  - active_div <= req_div
  - bit counter and os accumulator clear
  - rate_changed = 1 for exactly that cycle
  - no tick is produced that cycle
- Request while busy: the request is not latched. Commit happens on the first cycle both idles are high and req_div still differs. A request withdrawn before then is never applied.
- Bit counter:
  - Counts 0 .. active_div-1.
  - bit_tick is registered; it is high in the cycle after the counter holds active_div-1.
  - The counter wraps to 0 on the same edge.
  - The first bit_tick after reset release or a commit appears in cycle active_div (cycles numbered from 1).
- Oversample accumulator, width DIV_W+1:
  - Each cycle, acc_next = acc + OVERSAMPLE.
  - If acc_next >= active_div: acc <= acc_next - active_div and os_tick is pulsed next cycle. Otherwise acc <= acc_next.
  - Result: exactly OVERSAMPLE os_ticks per active_div cycles, spacing differing by at most 1 cycle. No drift against bit_tick.
- resync:
  - Clears bit counter and accumulator on that edge; no tick that cycle.
  - Next bit_tick occurs active_div cycles later.
  - resync held high suppresses all ticks.
- Priority: rst > commit > resync > normal count. Commit and resync in the same cycle produce one clear and a rate_changed pulse.
- bit_tick and os_tick may both be high in the same cycle. Every bit_tick cycle coincides with an os_tick.
- active_div never changes while tx_idle or rx_idle is low.

Decomposition:
- Shared package uart_pkg holds:
  - BR_SEL_W = 3
  - the baud-rate constant array
  - function calc_div(clk_hz, baud) returning a rounded divisor
  - MIN_DIV(OVERSAMPLE)
- One sub-module, uart_tick_div: bit counter plus Bresenham oversample accumulator.
  - Inputs: clk, rst, clr, div.
  - Outputs: bit_tick, os_tick.
- Top level holds the request mux, clamp and commit logic.

Test Plan:
- Reset, idles high, br_sel=6, use_custom=0 -> active_div=868, rate_changed never pulses, bit_tick in cycles 868 and 1736, exactly 16 os_ticks per 868 cycles with gaps of 54 or 55.
- br_sel 6->1 with tx_idle=0 for 500 cycles, then both idle -> active_div stays 868 until the idle cycle, then 10417 with one rate_changed pulse; next bit_tick 10417 cycles later.
- use_custom=1, custom_div=5 -> clamped, active_div=32, os_tick every 2 cycles, bit_tick every 32.
- Pulse resync at cycle 400 of an 868 period -> no bit_tick at 868; next bit_tick 868 cycles after the resync edge.
- br_sel toggles 6->7->6 while rx_idle=0 -> no commit, active_div stays 868, no rate_changed pulse.
- Assert rst mid-period with active_div=434 and br_sel=3 -> next cycle active_div=868 (RESET_SEL), counters zero, no stray tick; commit to 5208 follows once rst drops with idles high.
